// File: rtl/mem_arbiter_if.sv
// Request/response and ROM-side signal bundle for mem_arbiter.
// Modports:
//   slave  - arbiter side: takes fetch/load requests and ROM read data, drives grants,
//            response pulses, shared response data/error, busy and the ROM address.
//   master - requester/ROM side (the mirror of slave).
// Parameters: MEM_DEPTH is the address MSB index (addresses are MEM_DEPTH+1 bits);
// MEM_EXTRA is the extra-field width (data is 2**MEM_EXTRA*8 bits).
interface mem_arbiter_if #(
  parameter int unsigned MEM_DEPTH = 6,
  parameter int unsigned MEM_EXTRA = 4
);
  localparam int unsigned AW = MEM_DEPTH + 1;
  localparam int unsigned DW = (2 ** MEM_EXTRA) * 8;

  logic          f_req;
  logic [AW-1:0] f_addr;
  logic [MEM_EXTRA-1:0] f_extra;
  logic          f_gnt;
  logic          f_valid;

  logic          l_req;
  logic [AW-1:0] l_addr;
  logic [MEM_EXTRA-1:0] l_extra;
  logic          l_gnt;
  logic          l_valid;

  logic [DW-1:0] rsp_data;
  logic          rsp_error;
  logic          busy;

  logic [AW-1:0] mem_addr;
  logic [MEM_EXTRA-1:0] mem_extra;
  logic [DW-1:0] mem_data;
  logic          mem_error;

  modport slave (
    input  f_req, f_addr, f_extra, l_req, l_addr, l_extra, mem_data, mem_error,
    output f_gnt, f_valid, l_gnt, l_valid, rsp_data, rsp_error, busy, mem_addr, mem_extra
  );

  modport master (
    output f_req, f_addr, f_extra, l_req, l_addr, l_extra, mem_data, mem_error,
    input  f_gnt, f_valid, l_gnt, l_valid, rsp_data, rsp_error, busy, mem_addr, mem_extra
  );
endinterface

// File: rtl/mem_arbiter.sv
// Two-port (fetch/load) arbiter in front of a single registered-read ROM.
// One access at a time: IDLE -> READ -> RESP, with a new grant allowed in IDLE or RESP,
// so back-to-back traffic sustains one access every two cycles with 2-cycle latency.
// Ports:
//   clk   - clock, all state on the rising edge
//   reset - asynchronous active-high reset; aborts any access in flight
//   bus   - mem_arbiter_if.slave: requests, grants, response pulses, shared response
//           data/error, busy, and the registered ROM address/extra plus ROM read data
// Configuration: define MEM_ARB_FIXED_PRIORITY_EN to make fetch always win a tie;
// otherwise ties are resolved round-robin.
module mem_arbiter #(
  parameter int unsigned MEM_DEPTH = 6,
  parameter int unsigned MEM_EXTRA = 4
) (
  input logic           clk,
  input logic           reset,
  mem_arbiter_if.slave  bus
);
  localparam int unsigned AW = MEM_DEPTH + 1;
  localparam int unsigned DW = (2 ** MEM_EXTRA) * 8;

  typedef enum logic [1:0] {StIdle, StRead, StResp} state_e;

  state_e               state_q;
  logic                 owner_q;     // 0: fetch, 1: load
  logic [AW-1:0]        mem_addr_q;
  logic [MEM_EXTRA-1:0] mem_extra_q;
  logic [DW-1:0]        rsp_data_q;  // last delivered data, shown outside RESP
  logic                 rsp_error_q;
  logic                 busy_q;
  logic                 f_valid_q;
  logic                 l_valid_q;
`ifndef MEM_ARB_FIXED_PRIORITY_EN
  logic                 prio_q;      // 0: fetch holds priority, 1: load
`endif

  logic can_grant;
  logic grant;
  logic pick_load;
  logic in_resp;

  always_comb begin
    in_resp   = (state_q == StResp);
    // Gated by reset so no grant pulses while the arbiter is held in reset.
    can_grant = ((state_q == StIdle) || in_resp) && !reset;
`ifdef MEM_ARB_FIXED_PRIORITY_EN
    pick_load = bus.l_req && !bus.f_req;
`else
    pick_load = bus.l_req && (!bus.f_req || prio_q);
`endif
    grant     = can_grant && (bus.f_req || bus.l_req);
  end

  assign bus.f_gnt     = grant && !pick_load;
  assign bus.l_gnt     = grant && pick_load;
  assign bus.f_valid   = f_valid_q;
  assign bus.l_valid   = l_valid_q;
  // ROM data is live during RESP; afterwards the captured copy is held.
  assign bus.rsp_data  = in_resp ? bus.mem_data : rsp_data_q;
  assign bus.rsp_error = in_resp ? bus.mem_error : rsp_error_q;
  assign bus.busy      = busy_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_extra = mem_extra_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= StIdle;
      owner_q     <= 1'b0;
      mem_addr_q  <= '0;
      mem_extra_q <= '0;
      rsp_data_q  <= '0;
      rsp_error_q <= 1'b0;
      busy_q      <= 1'b0;
      f_valid_q   <= 1'b0;
      l_valid_q   <= 1'b0;
`ifndef MEM_ARB_FIXED_PRIORITY_EN
      prio_q      <= 1'b0;
`endif
    end else begin
      f_valid_q <= 1'b0;
      l_valid_q <= 1'b0;
      case (state_q)
        StIdle, StResp: begin
          if (in_resp) begin
            rsp_data_q  <= bus.mem_data;
            rsp_error_q <= bus.mem_error;
          end
          if (grant) begin
            mem_addr_q  <= pick_load ? bus.l_addr : bus.f_addr;
            mem_extra_q <= pick_load ? bus.l_extra : bus.f_extra;
            owner_q     <= pick_load;
`ifndef MEM_ARB_FIXED_PRIORITY_EN
            prio_q      <= !pick_load;
`endif
            busy_q      <= 1'b1;
            state_q     <= StRead;
          end else begin
            busy_q      <= 1'b0;
            state_q     <= StIdle;
          end
        end
        StRead: begin
          // ROM output becomes valid on this edge, so the response pulse lines up with it.
          f_valid_q <= !owner_q;
          l_valid_q <= owner_q;
          state_q   <= StResp;
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= StIdle;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;
  localparam int unsigned MD = 6;
  localparam int unsigned ME = 4;
  localparam int unsigned AW = MD + 1;
  localparam int unsigned DW = (2 ** ME) * 8;

  logic clk = 1'b0;
  logic reset;
  int   lower_bound = 0;

  mem_arbiter_if #(.MEM_DEPTH(MD), .MEM_EXTRA(ME)) bus ();

  mem_arbiter #(.MEM_DEPTH(MD), .MEM_EXTRA(ME)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] rom_fn(input logic [AW-1:0] a, input logic [ME-1:0] e);
    logic [31:0]   w;
    logic [DW-1:0] d;
    w = (32'(a) * 32'h9E37_79B1) ^ (32'(e) << 24) ^ 32'h5A5A_0000;
    d = '0;
    for (int i = 0; i < int'(DW / 32); i++) d[i*32 +: 32] = w + 32'(i);
    return d;
  endfunction

  // ROM: read registered one cycle after address sampled.
  always @(posedge clk) begin
    bus.mem_data  <= rom_fn(bus.mem_addr, bus.mem_extra);
    bus.mem_error <= (int'(bus.mem_addr) < lower_bound);
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model: one access may start every 2 cycles; response due 2 cycles later.
  typedef struct {
    int            due;
    bit            owner;
    logic [DW-1:0] data;
    bit            err;
  } rsp_t;

  rsp_t          exp_q[$];
  int            cyc = 0;
  int            last_gnt = -100;
  bit            prio_l = 1'b0;
  logic [DW-1:0] last_data = '0;
  bit            last_err = 1'b0;

  task automatic model_reset();
    exp_q.delete();
    last_gnt  = cyc - 100;
    prio_l    = 1'b0;
    last_data = '0;
    last_err  = 1'b0;
  endtask

  // Called at posedge+1; checks the current cycle, advances to next posedge+1.
  task automatic step(output bit gf, output bit gl);
    bit            free, win_l, g;
    rsp_t          r;
    logic [AW-1:0] ga;
    logic [ME-1:0] ge;
    @(negedge clk);
    free = (cyc - last_gnt) >= 2;
    g    = free && (bus.f_req || bus.l_req);
    if (bus.f_req && bus.l_req) begin
`ifdef MEM_ARB_FIXED_PRIORITY_EN
      win_l = 1'b0;
`else
      win_l = prio_l;
`endif
    end else begin
      win_l = bus.l_req;
    end
    gf = g && !win_l;
    gl = g && win_l;
    check("busy", DW'(bus.busy), DW'((cyc - last_gnt) == 1 || (cyc - last_gnt) == 2));
    check("f_gnt", DW'(bus.f_gnt), DW'(gf));
    check("l_gnt", DW'(bus.l_gnt), DW'(gl));
    if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
      r = exp_q.pop_front();
      check("f_valid", DW'(bus.f_valid), DW'(!r.owner));
      check("l_valid", DW'(bus.l_valid), DW'(r.owner));
      check("rsp_data", bus.rsp_data, r.data);
      check("rsp_error", DW'(bus.rsp_error), DW'(r.err));
      last_data = r.data;
      last_err  = r.err;
    end else begin
      check("no_valid", DW'({bus.f_valid, bus.l_valid}), '0);
      check("rsp_data_hold", bus.rsp_data, last_data);
      check("rsp_error_hold", DW'(bus.rsp_error), DW'(last_err));
    end
    ga = win_l ? bus.l_addr : bus.f_addr;
    ge = win_l ? bus.l_extra : bus.f_extra;
    if (g) begin
      r.due   = cyc + 2;
      r.owner = win_l;
      r.data  = rom_fn(ga, ge);
      r.err   = int'(ga) < lower_bound;
      exp_q.push_back(r);
      last_gnt = cyc;
      prio_l   = !win_l;
    end
    @(posedge clk);
    #1;
    cyc++;
    if (g) begin
      check("mem_addr", DW'(bus.mem_addr), DW'(ga));
      check("mem_extra", DW'(bus.mem_extra), DW'(ge));
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #1;
    check("rst_busy", DW'(bus.busy), '0);
    check("rst_mem_addr", DW'(bus.mem_addr), '0);
    check("rst_mem_extra", DW'(bus.mem_extra), '0);
    check("rst_gnt", DW'({bus.f_gnt, bus.l_gnt}), '0);
    check("rst_valid", DW'({bus.f_valid, bus.l_valid}), '0);
    check("rst_rsp_data", bus.rsp_data, '0);
    check("rst_rsp_error", DW'(bus.rsp_error), '0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    cyc++;
    model_reset();
  endtask

  task automatic idle(input int n);
    bit gf, gl;
    for (int i = 0; i < n; i++) step(gf, gl);
  endtask

  initial begin
    bit gf, gl;
    reset       = 1'b1;
    bus.f_req   = 1'b1;  // held during reset: must not be granted
    bus.f_addr  = AW'(33);
    bus.f_extra = '0;
    bus.l_req   = 1'b0;
    bus.l_addr  = '0;
    bus.l_extra = '0;
    do_reset();

    // Fetch-only from reset release.
    step(gf, gl);
    bus.f_req = 1'b0;
    idle(4);

    // Contention with both held: alternating grants.
    do_reset();
    bus.f_req = 1'b1; bus.f_addr = AW'(4);
    bus.l_req = 1'b1; bus.l_addr = AW'(8); bus.l_extra = ME'(3);
    idle(8);
    bus.f_req = 1'b0; bus.l_req = 1'b0;
    idle(3);

    // Error response below the ROM lower bound.
    lower_bound = 10;
    bus.l_req = 1'b1; bus.l_addr = AW'(2); bus.l_extra = '0;
    step(gf, gl);
    bus.l_req = 1'b0;
    idle(3);

    // Reset while in READ aborts the access.
    bus.f_req = 1'b1; bus.f_addr = AW'(50);
    step(gf, gl);
    bus.f_req = 1'b0;
    do_reset();
    idle(4);

    // Load request arriving during READ is granted in RESP.
    bus.f_req = 1'b1; bus.f_addr = AW'(20);
    step(gf, gl);
    bus.f_req = 1'b0;
    bus.l_req = 1'b1; bus.l_addr = AW'(21); bus.l_extra = ME'(5);
    step(gf, gl);
    step(gf, gl);
    bus.l_req = 1'b0;
    idle(4);

    // Randomized traffic with occasional resets.
    for (int i = 0; i < 3000; i++) begin
      step(gf, gl);
      if (gf || !bus.f_req) begin
        bus.f_req   = 1'($urandom_range(0, 1));
        bus.f_addr  = AW'($urandom);
        bus.f_extra = ME'($urandom);
      end
      if (gl || !bus.l_req) begin
        bus.l_req   = 1'($urandom_range(0, 1));
        bus.l_addr  = AW'($urandom);
        bus.l_extra = ME'($urandom);
      end
      if ($urandom_range(0, 199) == 0) do_reset();
    end
    bus.f_req = 1'b0;
    bus.l_req = 1'b0;
    idle(4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
